// File: rtl/div_req_ctrl_pkg.sv
// Shared state encodings and special-result constants for the divider request front-end.
package div_req_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Widths up to 64 bits; callers cast the result down to their DATA_W.
    function automatic logic [63:0] div_all_ones(input int w);
        if (w >= 64)
            return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] div_min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_req_ctrl.sv
// Valid/ready front-end for the subtract-shift divider core: filters divide-by-zero and
// signed overflow locally, otherwise runs the core and holds its result for the consumer.
module div_req_ctrl
    import div_req_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_sign,
    input  logic [DATA_W-1:0] req_dividend,
    input  logic [DATA_W-1:0] req_divisor,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_quotient,
    output logic [DATA_W-1:0] rsp_remainder,
    output logic              rsp_dz,
    output logic              rsp_ovf,
    output logic              busy,
    output logic              core_en,
    output logic              core_sign,
    output logic [DATA_W-1:0] core_dividend,
    output logic [DATA_W-1:0] core_divisor,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_quotient,
    input  logic [DATA_W-1:0] core_remainder
);

    localparam logic [DATA_W-1:0] DIV_ALL_ONES = DATA_W'(div_all_ones(DATA_W));
    localparam logic [DATA_W-1:0] DIV_MIN_NEG  = DATA_W'(div_min_neg(DATA_W));

    logic [1:0] r_state;
    logic       r_run_first;
    logic       w_accept;
    logic       w_dz;
    logic       w_ovf;

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign busy      = (r_state != ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_dz      = (req_divisor == '0);
    assign w_ovf     = req_sign && (req_dividend == DIV_MIN_NEG) && (req_divisor == DIV_ALL_ONES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_run_first   <= 1'b0;
            core_en       <= 1'b0;
            core_sign     <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dz        <= 1'b0;
            rsp_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_dz) begin
                            rsp_quotient  <= DIV_ALL_ONES;
                            rsp_remainder <= req_dividend;
                            rsp_dz        <= 1'b1;
                            rsp_ovf       <= 1'b0;
                            rsp_valid     <= 1'b1;
                            r_state       <= ST_RESP;
                        end else if (w_ovf) begin
                            rsp_quotient  <= req_dividend;
                            rsp_remainder <= '0;
                            rsp_dz        <= 1'b0;
                            rsp_ovf       <= 1'b1;
                            rsp_valid     <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            core_sign     <= req_sign;
                            core_dividend <= req_dividend;
                            core_divisor  <= req_divisor;
                            core_en       <= 1'b1;
                            r_run_first   <= 1'b1;
                            r_state       <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // A done left over from a previous run is ignored on the first RUN cycle.
                    r_run_first <= 1'b0;
                    if (!r_run_first && core_done) begin
                        rsp_quotient  <= core_quotient;
                        rsp_remainder <= core_remainder;
                        rsp_dz        <= 1'b0;
                        rsp_ovf       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        core_en       <= 1'b0;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_req_ctrl.md
Name: div_req_ctrl

Overview:
Request/response front-end for the sequential subtract-shift divider core (div_subshift). It accepts divide operations on a valid/ready request port and resolves divide-by-zero and signed overflow itself, without running the core. All other operations go to the core: it drives the core's en/sign/operands, waits for core done, captures quotient/remainder, and holds them on a valid/ready response port. It also pulses core en low between operations so the core restarts cleanly.

Parameters:
DATA_W, 32, operand/result width; must match the attached core.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_sign  in  1  1 = signed (two's complement) operation
req_dividend  in  DATA_W  dividend
req_divisor  in  DATA_W  divisor
rsp_valid  out  1  result present
rsp_ready  in  1  consumer takes result
rsp_quotient  out  DATA_W  quotient
rsp_remainder  out  DATA_W  remainder
rsp_dz  out  1  divide-by-zero flag
rsp_ovf  out  1  signed overflow flag
busy  out  1  state != IDLE
core_en  out  1  to core en (registered)
core_sign  out  1  to core sign (registered)
core_dividend  out  DATA_W  to core dividend (registered)
core_divisor  out  DATA_W  to core divisor (registered)
core_done  in  1  from core done
core_quotient  in  DATA_W  from core
core_remainder  in  DATA_W  from core

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset values: state=IDLE, core_en=0, rsp_valid=0, rsp_dz=0, rsp_ovf=0, rsp_quotient=0, rsp_remainder=0, core_sign/core_dividend/core_divisor=0. req_ready is combinational: req_ready = (state==IDLE) && !rst.
- FSM states are IDLE, RUN, RESP.
- IDLE:
  - On req_valid && req_ready, the request is accepted.
  - If divisor==0: go to RESP with q=all-ones, r=dividend, dz=1. This applies to signed and unsigned requests.
  - Else if sign && dividend==2^(DATA_W-1) && divisor==all-ones: go to RESP with q=dividend, r=0, ovf=1.
  - Else: register the operands into core_*, set core_en=1, go to RUN.
- RUN:
  - Hold core_en=1 and the operands stable.
  - When core_done==1: capture core_quotient/core_remainder into rsp_*, set core_en=0 (this clears the core), go to RESP.
  - core_done must not be acted on in the first cycle of RUN. The core cannot assert it that early, and a stale done is masked.
- RESP:
  - rsp_valid=1; all rsp_* fields are stable while rsp_valid is high.
  - On rsp_ready: rsp_valid=0 and go to IDLE. The next request can be accepted on the following edge, which guarantees at least one cycle of core_en=0 between core runs.
  - No new request is accepted in RESP: one operation in flight, no bypass from rsp_ready to req_ready.
- Latency, counted in rising edges from the accepting edge to the first cycle rsp_valid is high:
  - Special case (dz/ovf): 1.
  - Core case with the standard core: DATA_W+5, i.e. 37 for DATA_W=32.
- Flags rsp_dz and rsp_ovf are 0 for core results and are rewritten on every response.
- Reset mid-operation (RUN or RESP): the block returns to IDLE on that edge, core_en=0 and rsp_valid=0; the pending result is discarded.
- req_* values are ignored while req_ready=0.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, RESP=2'd2;
  - the special-result constants: DIV_ALL_ONES and DIV_MIN_NEG, as functions of DATA_W.
- No sub-module inside this block. The core is instantiated alongside it by the parent wrapper, with core_* connected port-to-port.

Test Plan:
1. Unsigned 100/7, rsp_ready=1 → q=14, r=2, dz=0, ovf=0; rsp_valid appears 37 edges after accept.
2. Signed 0xFFFFFFF9 (-7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF; then signed 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
3. 0x1234/0, both sign=0 and sign=1 → q=0xFFFFFFFF, r=0x1234, dz=1; rsp_valid after 1 edge; core_en stays 0 throughout.
4. Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0, ovf=1, core never enabled. The same operands unsigned → core run, q=0, r=0x80000000.
5. Back-to-back requests with rsp_ready held low 10 cycles → rsp_* stable, req_ready=0; after the handshake, core_en is low for at least 1 cycle before the next run.
6. Assert rst for 1 cycle at edge 15 of a RUN → next cycle state IDLE, core_en=0, rsp_valid=0; a fresh 9/3 request then returns q=3, r=0.
